// File: rtl/multi_pump_fsm.sv
// Multi-channel pump controller: one off/standby/working FSM per channel, shared
// edge-triggered command bus, concurrency limit, minimum run time and emergency stop.
module multi_pump_fsm #(
  parameter int N_CH       = 4,
  parameter int CH_W       = 2,
  parameter int MAX_ACTIVE = 2,
  parameter int MIN_RUN    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [1:0]        command,
  input  logic              estop,
  output logic [N_CH-1:0]   pump,
  output logic [N_CH-1:0]   led,
  output logic [CH_W:0]     active_count,
  output logic              reject
);

  localparam int CNT_W = (MIN_RUN < 1) ? 1 : $clog2(MIN_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MIN_RUN);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_STBY  = 2'd1,
    ST_WORK  = 2'd2,
    ST_ILL   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_OFF   = 2'b00,
    CMD_ON    = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_START = 2'b11
  } cmd_t;

  state_t            r_state [N_CH];
  logic [CNT_W-1:0]  r_run   [N_CH];
  logic [N_CH-1:0]   r_pump;
  logic [N_CH-1:0]   r_led;
  logic              r_reject;
  logic              r_update_prev;

  logic              w_event;
  logic              w_ch_ok;
  logic              w_room;
  cmd_t              w_cmd;
  logic [CH_W:0]     w_active;
  logic [N_CH-1:0]   w_hit;

  assign w_event = update & ~r_update_prev;
  assign w_ch_ok = (int'(ch_sel) < N_CH);
  assign w_cmd   = cmd_t'(command);
  assign w_room  = (int'(w_active) < MAX_ACTIVE);

  always_comb begin
    w_active = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_active = w_active + (CH_W+1)'(r_pump[i]);
    end
  end

  // Decoded channel strobe avoids indexing the state array with an out-of-range ch_sel.
  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_hit[i] = w_event & w_ch_ok & ~estop & (ch_sel == CH_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_update_prev <= 1'b0;
      r_reject      <= 1'b0;
      r_pump        <= '0;
      r_led         <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_state[i] <= ST_OFF;
        r_run[i]   <= '0;
      end
    end else begin
      r_update_prev <= update;
      r_reject      <= w_event & (estop | ~w_ch_ok);
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (estop) begin
          r_state[i] <= ST_OFF;
          r_run[i]   <= '0;
          r_pump[i]  <= 1'b0;
          r_led[i]   <= 1'b0;
        end else begin
          case (r_state[i])
            ST_OFF: begin
              r_run[i] <= '0;
              if (w_hit[i] && w_cmd == CMD_ON) begin
                r_state[i] <= ST_STBY;
                r_pump[i]  <= 1'b0;
                r_led[i]   <= 1'b1;
              end
            end
            ST_STBY: begin
              r_run[i] <= '0;
              if (w_hit[i]) begin
                if (w_cmd == CMD_OFF) begin
                  r_state[i] <= ST_OFF;
                  r_pump[i]  <= 1'b0;
                  r_led[i]   <= 1'b0;
                end else if (w_cmd == CMD_START) begin
                  if (w_room) begin
                    r_state[i] <= ST_WORK;
                    r_pump[i]  <= 1'b1;
                    r_led[i]   <= 1'b1;
                  end else begin
                    r_reject <= 1'b1;
                  end
                end
              end
            end
            ST_WORK: begin
              r_run[i] <= (r_run[i] == RUN_MAX) ? r_run[i] : r_run[i] + 1'b1;
              if (w_hit[i]) begin
                if (w_cmd == CMD_OFF) begin
                  r_state[i] <= ST_OFF;
                  r_run[i]   <= '0;
                  r_pump[i]  <= 1'b0;
                  r_led[i]   <= 1'b0;
                end else if (w_cmd == CMD_STOP) begin
                  if (r_run[i] == RUN_MAX) begin
                    r_state[i] <= ST_STBY;
                    r_run[i]   <= '0;
                    r_pump[i]  <= 1'b0;
                    r_led[i]   <= 1'b1;
                  end else begin
                    r_reject <= 1'b1;
                  end
                end
              end
            end
            default: begin
              r_state[i] <= ST_OFF;
              r_run[i]   <= '0;
              r_pump[i]  <= 1'b0;
              r_led[i]   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign pump         = r_pump;
  assign led          = r_led;
  assign active_count = w_active;
  assign reject       = r_reject;

endmodule

// File: tb/tb_multi_pump_fsm.sv
// Randomised scoreboard bench for multi_pump_fsm against a channel-level reference model.
module tb_multi_pump_fsm;
  localparam int N    = 4;
  localparam int CW   = 3;
  localparam int MAXA = 2;
  localparam int MINR = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          update;
  logic [CW-1:0] ch_sel;
  logic [1:0]    command;
  logic          estop;
  logic [N-1:0]  pump;
  logic [N-1:0]  led;
  logic [CW:0]   active_count;
  logic          reject;

  multi_pump_fsm #(.N_CH(N), .CH_W(CW), .MAX_ACTIVE(MAXA), .MIN_RUN(MINR)) dut (
    .clk(clk), .reset(reset), .update(update), .ch_sel(ch_sel), .command(command),
    .estop(estop), .pump(pump), .led(led), .active_count(active_count), .reject(reject)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] pump;
    logic [N-1:0] led;
    logic [CW:0]  ac;
    logic         rej;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: 0 = off, 1 = standby, 2 = working; entry edge index per channel.
  int m_st [N];
  int m_entry [N];
  int m_edge;
  bit m_prev;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0;
      m_entry[i] = 0;
    end
    m_edge = 0;
    m_prev = 0;
  endtask

  function automatic int m_working();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_st[i] == 2) c++;
    return c;
  endfunction

  task automatic model_edge(input bit upd, input int ch, input int cmd, input bit es,
                            output exp_t e);
    bit ev;
    e = '0;
    m_edge++;
    ev = upd && !m_prev;
    m_prev = upd;
    if (es) begin
      for (int i = 0; i < N; i++) m_st[i] = 0;
      e.rej = ev;
    end else if (ev) begin
      if (ch >= N) e.rej = 1'b1;
      else if (m_st[ch] == 0) begin
        if (cmd == 1) m_st[ch] = 1;
      end else if (m_st[ch] == 1) begin
        if (cmd == 0) m_st[ch] = 0;
        else if (cmd == 3) begin
          if (m_working() < MAXA) begin
            m_st[ch] = 2;
            m_entry[ch] = m_edge;
          end else e.rej = 1'b1;
        end
      end else begin
        if (cmd == 0) m_st[ch] = 0;
        // counter reads min(edges since entry - 1, MINR) just before this edge
        else if (cmd == 2) begin
          if (m_edge - m_entry[ch] - 1 >= MINR) m_st[ch] = 1;
          else e.rej = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      e.pump[i] = (m_st[i] == 2);
      e.led[i]  = (m_st[i] != 0);
    end
    e.ac = (CW+1)'(m_working());
  endtask

  task automatic apply(input bit upd, input int ch, input int cmd, input bit es);
    exp_t e;
    update  = upd;
    ch_sel  = CW'(ch);
    command = 2'(cmd);
    estop   = es;
    model_edge(upd, ch, cmd, es, e);
    q.push_back(e);
  endtask

  task automatic step(input bit upd, input int ch, input int cmd, input bit es);
    @(negedge clk);
    apply(upd, ch, cmd, es);
  endtask

  task automatic issue(input int ch, input int cmd);
    step(1, ch, cmd, 0);
    step(0, ch, cmd, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (pump !== e.pump || led !== e.led || active_count !== e.ac || reject !== e.rej) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: pump=%b led=%b ac=%0d rej=%b expected pump=%b led=%b ac=%0d rej=%b",
                   $time, pump, led, active_count, reject, e.pump, e.led, e.ac, e.rej);
        end
      end
    end
  end

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
  endtask

  initial begin : stim
    reset = 1'b1; update = 1'b0; ch_sel = '0; command = 2'b00; estop = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_now("reset_pump", 32'(pump), 0);
    check_now("reset_led", 32'(led), 0);
    check_now("reset_ac", 32'(active_count), 0);
    check_now("reset_rej", 32'(reject), 0);
    reset = 1'b0;

    // directed: basic on/start, concurrency limit, min-run, held update, estop, bad channel
    issue(1, 1); issue(1, 3); idle(2);
    issue(0, 1); issue(0, 3); issue(2, 1); issue(2, 3); idle(2);
    issue(1, 0); issue(2, 0); idle(1);
    issue(0, 2); idle(1);
    issue(0, 2); idle(8); issue(0, 2); issue(0, 3); issue(0, 0); idle(2);
    step(1, 0, 1, 0);
    for (int i = 0; i < 19; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    issue(0, 3); issue(3, 1); issue(3, 3); idle(1);
    step(1, 1, 1, 1); step(0, 1, 1, 1); step(0, 0, 0, 0); idle(3);
    issue(5, 1); issue(7, 3); idle(2);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 5), $urandom_range(0, 3),
           $urandom_range(0, 60) == 0);
    end
    idle(2);
    issue(0, 1); issue(0, 3); issue(2, 1);
    drain();

    // asynchronous reset between edges, then release with update already high
    #2 reset = 1'b1;
    #1;
    check_now("async_pump", 32'(pump), 0);
    check_now("async_led", 32'(led), 0);
    check_now("async_ac", 32'(active_count), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    apply(1, 2, 1, 0);
    step(1, 2, 0, 0);
    step(0, 2, 0, 0);
    issue(2, 3);
    idle(3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
